// File: rtl/dtl_pkg.sv
// Shared DTL definitions: master FSM state encoding and command direction constants.
package dtl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } dtl_state_t;

  localparam logic DTL_READ  = 1'b1;
  localparam logic DTL_WRITE = 1'b0;

endpackage

// File: rtl/dtl_master.sv
// DTL burst master: accepts one client request, issues the DTL command, then
// streams write beats from the client or read beats back to it.
module dtl_master
  import dtl_pkg::*;
#(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iReqValid,
  output logic                              oReqAccept,
  input  logic                              iReqReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iReqAddress,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0]  iReqBlockSize,
  input  logic                              iWrValid,
  output logic                              oWrAccept,
  input  logic [INTERFACE_WIDTH-1:0]        iWrData,
  input  logic [INTERFACE_WIDTH/8-1:0]      iWrEnable,
  output logic                              oRdValid,
  input  logic                              iRdAccept,
  output logic [INTERFACE_WIDTH-1:0]        oRdData,
  output logic                              oRdLast,
  output logic                              oDTL_CommandValid,
  input  logic                              iDTL_CommandAccept,
  output logic [INTERFACE_ADDR_WIDTH-1:0]   oDTL_Address,
  output logic                              oDTL_CommandReadWrite,
  output logic [INTERFACE_BLOCK_WIDTH-1:0]  oDTL_BlockSize,
  input  logic                              iDTL_ReadValid,
  input  logic                              iDTL_ReadLast,
  output logic                              oDTL_ReadAccept,
  input  logic [INTERFACE_WIDTH-1:0]        iDTL_ReadData,
  output logic                              oDTL_WriteValid,
  output logic                              oDTL_WriteLast,
  input  logic                              iDTL_WriteAccept,
  output logic [INTERFACE_WIDTH/8-1:0]      oDTL_WriteEnable,
  output logic [INTERFACE_WIDTH-1:0]        oDTL_WriteData
);

  dtl_state_t                       state_q, state_d;
  logic [INTERFACE_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                             rw_q, rw_d;
  logic [INTERFACE_BLOCK_WIDTH-1:0] size_q, size_d;
  logic [INTERFACE_BLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic                             rd_last;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command fields come straight from the request registers; the target owns address increment.
  assign oDTL_Address          = addr_q;
  assign oDTL_CommandReadWrite = rw_q;
  assign oDTL_BlockSize        = size_q;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    rw_d              = rw_q;
    size_d            = size_q;
    cnt_d             = cnt_q;
    rd_last           = 1'b0;
    oReqAccept        = 1'b0;
    oDTL_CommandValid = 1'b0;
    oDTL_WriteValid   = 1'b0;
    oDTL_WriteLast    = 1'b0;
    oDTL_WriteData    = '0;
    oDTL_WriteEnable  = '0;
    oWrAccept         = 1'b0;
    oRdValid          = 1'b0;
    oRdData           = '0;
    oRdLast           = 1'b0;
    oDTL_ReadAccept   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so nothing is accepted during reset.
        oReqAccept = ~iReset;
        if (iReqValid) begin
          addr_d  = iReqAddress;
          rw_d    = iReqReadWrite;
          size_d  = iReqBlockSize;
          cnt_d   = iReqBlockSize;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        oDTL_CommandValid = 1'b1;
        if (iDTL_CommandAccept)
          state_d = (rw_q == DTL_READ) ? ST_READ : ST_WRITE;
      end
      ST_WRITE: begin
        oDTL_WriteValid  = iWrValid;
        oWrAccept        = iDTL_WriteAccept;
        oDTL_WriteData   = iWrData;
        oDTL_WriteEnable = iWrEnable;
        oDTL_WriteLast   = (cnt_q == '0);
        if (iWrValid && iDTL_WriteAccept) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_READ: begin
        // An early target last ends the burst even if beats remain.
        rd_last         = (cnt_q == '0) | iDTL_ReadLast;
        oRdValid        = iDTL_ReadValid;
        oDTL_ReadAccept = iRdAccept;
        oRdData         = iDTL_ReadData;
        oRdLast         = rd_last;
        if (iDTL_ReadValid && iRdAccept) begin
          if (rd_last) state_d = ST_IDLE;
          else         cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtl_master.sv
// Directed bench for dtl_master: write burst, single-beat read with stalled
// command, early-terminated read, and reset mid-write.
module tb_dtl_master;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iReqValid;
  logic        oReqAccept;
  logic        iReqReadWrite;
  logic [31:0] iReqAddress;
  logic [4:0]  iReqBlockSize;
  logic        iWrValid;
  logic        oWrAccept;
  logic [31:0] iWrData;
  logic [3:0]  iWrEnable;
  logic        oRdValid;
  logic        iRdAccept;
  logic [31:0] oRdData;
  logic        oRdLast;
  logic        oDTL_CommandValid;
  logic        iDTL_CommandAccept;
  logic [31:0] oDTL_Address;
  logic        oDTL_CommandReadWrite;
  logic [4:0]  oDTL_BlockSize;
  logic        iDTL_ReadValid;
  logic        iDTL_ReadLast;
  logic        oDTL_ReadAccept;
  logic [31:0] iDTL_ReadData;
  logic        oDTL_WriteValid;
  logic        oDTL_WriteLast;
  logic        iDTL_WriteAccept;
  logic [3:0]  oDTL_WriteEnable;
  logic [31:0] oDTL_WriteData;

  int checks = 0;
  int errors = 0;

  dtl_master dut (
    .iClk(iClk), .iReset(iReset),
    .iReqValid(iReqValid), .oReqAccept(oReqAccept),
    .iReqReadWrite(iReqReadWrite), .iReqAddress(iReqAddress), .iReqBlockSize(iReqBlockSize),
    .iWrValid(iWrValid), .oWrAccept(oWrAccept), .iWrData(iWrData), .iWrEnable(iWrEnable),
    .oRdValid(oRdValid), .iRdAccept(iRdAccept), .oRdData(oRdData), .oRdLast(oRdLast),
    .oDTL_CommandValid(oDTL_CommandValid), .iDTL_CommandAccept(iDTL_CommandAccept),
    .oDTL_Address(oDTL_Address), .oDTL_CommandReadWrite(oDTL_CommandReadWrite),
    .oDTL_BlockSize(oDTL_BlockSize),
    .iDTL_ReadValid(iDTL_ReadValid), .iDTL_ReadLast(iDTL_ReadLast),
    .oDTL_ReadAccept(oDTL_ReadAccept), .iDTL_ReadData(iDTL_ReadData),
    .oDTL_WriteValid(oDTL_WriteValid), .oDTL_WriteLast(oDTL_WriteLast),
    .iDTL_WriteAccept(iDTL_WriteAccept), .oDTL_WriteEnable(oDTL_WriteEnable),
    .oDTL_WriteData(oDTL_WriteData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic no_data_activity(input string tag);
    chk({tag, "_wvalid"}, 64'(oDTL_WriteValid), 64'(0));
    chk({tag, "_rvalid"}, 64'(oRdValid), 64'(0));
    chk({tag, "_wracc"},  64'(oWrAccept), 64'(0));
    chk({tag, "_dracc"},  64'(oDTL_ReadAccept), 64'(0));
  endtask

  initial begin
    iReset = 1'b1;
    iReqValid = 0; iReqReadWrite = 0; iReqAddress = '0; iReqBlockSize = '0;
    iWrValid = 0; iWrData = '0; iWrEnable = '0; iRdAccept = 0;
    iDTL_CommandAccept = 0; iDTL_ReadValid = 0; iDTL_ReadLast = 0;
    iDTL_ReadData = '0; iDTL_WriteAccept = 0;

    // Reset state
    #12;
    chk("rst_reqacc", 64'(oReqAccept), 64'(0));
    chk("rst_cmdvalid", 64'(oDTL_CommandValid), 64'(0));
    chk("rst_addr", 64'(oDTL_Address), 64'(0));
    iReset = 1'b0;
    #1;
    chk("rel_reqacc", 64'(oReqAccept), 64'(1));
    step();

    // Write 0x100 size 3, target always ready
    iReqValid = 1; iReqReadWrite = 0; iReqAddress = 32'h100; iReqBlockSize = 5'd3;
    #1;
    chk("w_reqacc", 64'(oReqAccept), 64'(1));
    step();
    iReqValid = 0;
    #1;
    chk("w_cmdvalid", 64'(oDTL_CommandValid), 64'(1));
    chk("w_addr", 64'(oDTL_Address), 64'h100);
    chk("w_size", 64'(oDTL_BlockSize), 64'(3));
    chk("w_rw", 64'(oDTL_CommandReadWrite), 64'(0));
    chk("w_cmd_reqacc", 64'(oReqAccept), 64'(0));
    iDTL_CommandAccept = 1;
    step();
    iDTL_CommandAccept = 0;
    iWrValid = 1; iDTL_WriteAccept = 1;
    for (int b = 0; b < 4; b++) begin
      iWrData = 32'hA0 + 32'(b);
      iWrEnable = 4'hF ^ 4'(b);
      #1;
      $display("write beat %0d data=%0h last=%0b", b, oDTL_WriteData, oDTL_WriteLast);
      chk("w_valid", 64'(oDTL_WriteValid), 64'(1));
      chk("w_data", 64'(oDTL_WriteData), 64'hA0 + 64'(b));
      chk("w_en", 64'(oDTL_WriteEnable), 64'(4'hF ^ 4'(b)));
      chk("w_last", 64'(oDTL_WriteLast), 64'(b == 3));
      chk("w_wracc", 64'(oWrAccept), 64'(1));
      chk("w_cmdv_in_data", 64'(oDTL_CommandValid), 64'(0));
      step();
    end
    chk("w_idle", 64'(oReqAccept), 64'(1));
    chk("w_idle_cmdv", 64'(oDTL_CommandValid), 64'(0));
    no_data_activity("w_idle");
    iWrValid = 0; iDTL_WriteAccept = 0;

    // Read size 0, command stalled 5 cycles
    iReqValid = 1; iReqReadWrite = 1; iReqAddress = 32'h200; iReqBlockSize = 5'd0;
    step();
    iReqValid = 0; iReqAddress = 32'hFFFF; iReqBlockSize = 5'd9;
    iDTL_ReadValid = 1; iRdAccept = 1; iWrValid = 1; iDTL_WriteAccept = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      $display("stalled command cycle %0d addr=%0h size=%0d", c, oDTL_Address, oDTL_BlockSize);
      chk("r0_cmdvalid", 64'(oDTL_CommandValid), 64'(1));
      chk("r0_addr", 64'(oDTL_Address), 64'h200);
      chk("r0_size", 64'(oDTL_BlockSize), 64'(0));
      chk("r0_rw", 64'(oDTL_CommandReadWrite), 64'(1));
      no_data_activity("r0_stall");
      step();
    end
    iWrValid = 0; iDTL_WriteAccept = 0;
    iDTL_ReadValid = 0; iRdAccept = 0;
    iDTL_CommandAccept = 1;
    step();
    iDTL_CommandAccept = 0;
    iDTL_ReadValid = 1; iRdAccept = 1; iDTL_ReadData = 32'hDEAD_BEEF; iDTL_ReadLast = 0;
    #1;
    $display("read size0 beat data=%0h last=%0b", oRdData, oRdLast);
    chk("r0_rvalid", 64'(oRdValid), 64'(1));
    chk("r0_rdata", 64'(oRdData), 64'hDEAD_BEEF);
    chk("r0_rlast", 64'(oRdLast), 64'(1));
    chk("r0_racc", 64'(oDTL_ReadAccept), 64'(1));
    step();
    chk("r0_idle", 64'(oReqAccept), 64'(1));
    chk("r0_idle_rvalid", 64'(oRdValid), 64'(0));
    chk("r0_idle_rdata", 64'(oRdData), 64'(0));
    iDTL_ReadValid = 0; iRdAccept = 0;

    // Read size 7, target ends burst early on beat 3 (with one stall cycle)
    iReqValid = 1; iReqReadWrite = 1; iReqAddress = 32'h300; iReqBlockSize = 5'd7;
    step();
    iReqValid = 0;
    iDTL_CommandAccept = 1;
    #1;
    chk("r7_size", 64'(oDTL_BlockSize), 64'(7));
    step();
    iDTL_CommandAccept = 0;
    iRdAccept = 1; iDTL_ReadValid = 0;
    #1;
    chk("r7_stall_rvalid", 64'(oRdValid), 64'(0));
    chk("r7_stall_racc", 64'(oDTL_ReadAccept), 64'(1));
    step();
    for (int b = 1; b <= 3; b++) begin
      iDTL_ReadValid = 1;
      iDTL_ReadData = 32'h5000 + 32'(b);
      iDTL_ReadLast = (b == 3);
      #1;
      $display("read size7 beat %0d data=%0h last=%0b", b, oRdData, oRdLast);
      chk("r7_rvalid", 64'(oRdValid), 64'(1));
      chk("r7_rdata", 64'(oRdData), 64'h5000 + 64'(b));
      chk("r7_rlast", 64'(oRdLast), 64'(b == 3));
      step();
    end
    iDTL_ReadValid = 0; iDTL_ReadLast = 0; iRdAccept = 0;
    chk("r7_idle", 64'(oReqAccept), 64'(1));
    chk("r7_idle_racc", 64'(oDTL_ReadAccept), 64'(0));

    // Write size 3, reset asserted during beat 2
    iReqValid = 1; iReqReadWrite = 0; iReqAddress = 32'h400; iReqBlockSize = 5'd3;
    step();
    iReqValid = 0;
    iDTL_CommandAccept = 1;
    step();
    iDTL_CommandAccept = 0;
    iWrValid = 1; iDTL_WriteAccept = 1; iWrData = 32'h11; iWrEnable = 4'hF;
    #1;
    chk("wr_b1_last", 64'(oDTL_WriteLast), 64'(0));
    step();
    iWrData = 32'h22;
    #1;
    chk("wr_b2_valid", 64'(oDTL_WriteValid), 64'(1));
    iReset = 1'b1;
    #1;
    $display("reset during write beat 2 wvalid=%0b cmdvalid=%0b", oDTL_WriteValid, oDTL_CommandValid);
    chk("wr_rst_wvalid", 64'(oDTL_WriteValid), 64'(0));
    chk("wr_rst_wracc", 64'(oWrAccept), 64'(0));
    chk("wr_rst_cmdv", 64'(oDTL_CommandValid), 64'(0));
    chk("wr_rst_addr", 64'(oDTL_Address), 64'(0));
    step();
    iReset = 1'b0;
    #1;
    chk("wr_rel_reqacc", 64'(oReqAccept), 64'(1));
    no_data_activity("wr_rel");
    step();
    chk("wr_rel2_wvalid", 64'(oDTL_WriteValid), 64'(0));
    iWrValid = 0; iDTL_WriteAccept = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dtl_master.md
DTL_MASTER -- requirements
Module: dtl_master

Interface
REQ-001 SHALL have parameter INTERFACE_WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter INTERFACE_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter INTERFACE_BLOCK_WIDTH, default 5, block-size field width; beats = BlockSize+1.
REQ-004 SHALL have port iClk  input  1  sole clock, rising edge.
REQ-005 SHALL have port iReset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iReqValid  input  1  client request pending.
REQ-007 SHALL have port oReqAccept  output  1  request taken this cycle.
REQ-008 SHALL have port iReqReadWrite  input  1  1=read, 0=write.
REQ-009 SHALL have port iReqAddress  input  INTERFACE_ADDR_WIDTH  byte start address.
REQ-010 SHALL have port iReqBlockSize  input  INTERFACE_BLOCK_WIDTH  beats minus one.
REQ-011 SHALL have port iWrValid  input  1  client write beat available.
REQ-012 SHALL have port oWrAccept  output  1  client write beat consumed.
REQ-013 SHALL have port iWrData  input  INTERFACE_WIDTH  client write data.
REQ-014 SHALL have port iWrEnable  input  INTERFACE_WIDTH/8  client byte enables.
REQ-015 SHALL have port oRdValid  output  1  read beat to client valid.
REQ-016 SHALL have port iRdAccept  input  1  client takes read beat.
REQ-017 SHALL have port oRdData  output  INTERFACE_WIDTH  read data to client.
REQ-018 SHALL have port oRdLast  output  1  final read beat of burst.
REQ-019 SHALL have port oDTL_CommandValid  output  1  DTL command valid.
REQ-020 SHALL have port iDTL_CommandAccept  input  1  target accepts command.
REQ-021 SHALL have port oDTL_Address  output  INTERFACE_ADDR_WIDTH  command address.
REQ-022 SHALL have port oDTL_CommandReadWrite  output  1  1=read, 0=write.
REQ-023 SHALL have port oDTL_BlockSize  output  INTERFACE_BLOCK_WIDTH  command block size.
REQ-024 SHALL have port iDTL_ReadValid  input  1  target read beat valid.
REQ-025 SHALL have port iDTL_ReadLast  input  1  target marks final read beat.
REQ-026 SHALL have port oDTL_ReadAccept  output  1  master takes read beat.
REQ-027 SHALL have port iDTL_ReadData  input  INTERFACE_WIDTH  target read data.
REQ-028 SHALL have port oDTL_WriteValid  output  1  write beat valid.
REQ-029 SHALL have port oDTL_WriteLast  output  1  final write beat.
REQ-030 SHALL have port iDTL_WriteAccept  input  1  target takes write beat.
REQ-031 SHALL have port oDTL_WriteEnable  output  INTERFACE_WIDTH/8  byte enables.
REQ-032 SHALL have port oDTL_WriteData  output  INTERFACE_WIDTH  write data.

Function
REQ-033 SHALL implement FSM IDLE, CMD, WRITE, READ; handshake = valid & accept same rising edge.
REQ-034 IDLE: oReqAccept=1; on iReqValid register address, readwrite, blocksize, load beat counter = blocksize, go CMD.
REQ-035 CMD: oDTL_CommandValid=1, address/rw/size from registers, stable until iDTL_CommandAccept; then READ if rw=1 else WRITE.
REQ-036 WRITE: oDTL_WriteValid=iWrValid, oWrAccept=iDTL_WriteAccept, data/enables combinational pass-through, oDTL_WriteLast=(counter==0); each transfer decrements counter; transfer with counter==0 goes IDLE.
REQ-037 READ: oRdValid=iDTL_ReadValid, oDTL_ReadAccept=iRdAccept, oRdData=iDTL_ReadData, oRdLast=(counter==0)|iDTL_ReadLast; transfer with oRdLast=1 goes IDLE (early iDTL_ReadLast terminates burst).
REQ-038 Outside its state every valid/accept output SHALL be 0; no address increment in master (target increments).
REQ-039 Back-to-back bursts SHALL pass through IDLE: minimum one cycle between a last beat and next oDTL_CommandValid.
REQ-040 BlockSize 0 SHALL be a single beat with last asserted on it; counter never wraps below 0.

Reset
REQ-041 iReset SHALL asynchronously force IDLE, counter/registers to 0, all outputs 0 except oReqAccept=1 after release; mid-burst reset abandons the burst.

Structure
REQ-042 FSM state encodings and DTL read/write constants SHALL live in shared package dtl_pkg.
REQ-043 Single module, no sub-module; beat counter inline.

Verification
REQ-044 Write addr 0x100, size 3, target accepts every cycle -> 4 beats, WriteLast on beat 4 only, back in IDLE next cycle.
REQ-045 Read size 0 -> one beat, oRdLast=1 on it, oDTL_BlockSize=0.
REQ-046 Command held 5 cycles by CommandAccept=0 -> address/size stable, no data-phase activity.
REQ-047 Read size 7, iDTL_ReadLast at beat 3 -> oRdLast at beat 3, FSM to IDLE.
REQ-048 iReset asserted during beat 2 of size-3 write -> all valids 0 immediately, IDLE after release.
